// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int MS_MOD    = 10;
    localparam int SEC_T_MOD = 6;

    // Value a digit counter will hold after the coming edge.
    function automatic bcd_digit_t digit_next(bcd_digit_t d, logic inc, logic carry, logic clr);
        if (clr)   return 4'd0;
        if (!inc)  return d;
        if (carry) return 4'd0;
        return d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter, modulo MOD, with ripple carry out.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk_200,
    input  logic       resetb,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       carry
);

    localparam bcd_digit_t TOP = bcd_digit_t'(MOD - 1);

    bcd_digit_t r_digit;

    assign digit = r_digit;
    assign carry = inc && (r_digit == TOP);

    // Count up on inc, wrap at MOD; clear has priority.
    always_ff @(posedge clk_200 or negedge resetb) begin
        if (!resetb) begin
            r_digit <= 4'd0;
        end else if (clr) begin
            r_digit <= 4'd0;
        end else if (inc) begin
            r_digit <= (r_digit == TOP) ? 4'd0 : r_digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: mm:ss.mmm BCD count with start/stop, lap freeze and clear.
//
// state  | meaning
// IDLE   | cleared, waiting for start_stop
// RUN    | counting, display shows live count
// PAUSED | count held, display shows live count
// LAP    | counting, display frozen on lap latch
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic        clk_200,
    input  logic        resetb,
    input  logic        ms_tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [27:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam logic [6:0] MIN_MAX_C = 7'(MIN_MAX);

    sw_state_t   r_state;
    sw_state_t   w_next;
    bcd_digit_t  r_min_t;
    bcd_digit_t  r_min_o;
    logic [27:0] r_lap;
    logic [27:0] r_disp;
    logic        r_running;
    logic        r_lap_active;
    logic        r_overflow;

    // w_inc[i] increments digit i (0 = ms_o .. 4 = sec_t); w_inc[5] increments minutes.
    logic [5:0]  w_inc;
    bcd_digit_t  w_dig     [5];
    bcd_digit_t  w_dig_nxt [5];
    bcd_digit_t  w_min_t_nxt;
    bcd_digit_t  w_min_o_nxt;
    logic        w_wrap;
    logic        w_capture;
    logic [6:0]  w_min_val;
    logic [27:0] w_count;
    logic [27:0] w_count_nxt;
    logic [27:0] w_lap_nxt;

    // A tick coinciding with clear is dropped; the count uses the registered state.
    assign w_inc[0]  = ms_tick && !clear && (r_state == RUN || r_state == LAP);
    assign w_capture = (r_state == RUN) && lap && !start_stop && !clear;

    for (genvar g = 0; g < 5; g++) begin : g_dig
        bcd_digit_cnt #(
            .MOD (g == 4 ? SEC_T_MOD : MS_MOD)
        ) u_dig (
            .clk_200 (clk_200),
            .resetb  (resetb),
            .inc     (w_inc[g]),
            .clr     (clear),
            .digit   (w_dig[g]),
            .carry   (w_inc[g+1])
        );
    end

    assign w_min_val   = 7'(r_min_t) * 7'd10 + 7'(r_min_o);
    assign w_count     = {r_min_t, r_min_o, w_dig[4], w_dig[3], w_dig[2], w_dig[1], w_dig[0]};
    assign w_count_nxt = {w_min_t_nxt, w_min_o_nxt,
                          w_dig_nxt[4], w_dig_nxt[3], w_dig_nxt[2], w_dig_nxt[1], w_dig_nxt[0]};
    assign w_lap_nxt   = clear ? 28'd0 : (w_capture ? w_count : r_lap);

    // Look-ahead of the sub-second/second digits so the display register tracks the count.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_dig_nxt[i] = digit_next(w_dig[i], w_inc[i], w_inc[i+1], clear);
        end
    end

    // Minutes pair: two BCD digits sharing one combined limit; wrapping sets overflow.
    always_comb begin
        w_min_t_nxt = r_min_t;
        w_min_o_nxt = r_min_o;
        w_wrap      = 1'b0;
        if (clear) begin
            w_min_t_nxt = 4'd0;
            w_min_o_nxt = 4'd0;
        end else if (w_inc[5]) begin
            if (w_min_val == MIN_MAX_C) begin
                w_min_t_nxt = 4'd0;
                w_min_o_nxt = 4'd0;
                w_wrap      = 1'b1;
            end else if (r_min_o == 4'd9) begin
                w_min_o_nxt = 4'd0;
                w_min_t_nxt = r_min_t + 4'd1;
            end else begin
                w_min_o_nxt = r_min_o + 4'd1;
            end
        end
    end

    // Next-state decode; clear beats start_stop beats lap.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start_stop) w_next = RUN;
            RUN:     if (start_stop) w_next = PAUSED;
                     else if (lap)   w_next = LAP;
            PAUSED:  if (start_stop) w_next = RUN;
            LAP:     if (start_stop) w_next = PAUSED;
                     else if (lap)   w_next = RUN;
            default: w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end

    // State, minutes, lap latch and all registered outputs.
    always_ff @(posedge clk_200 or negedge resetb) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_min_t      <= 4'd0;
            r_min_o      <= 4'd0;
            r_lap        <= 28'd0;
            r_disp       <= 28'd0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_min_t      <= w_min_t_nxt;
            r_min_o      <= w_min_o_nxt;
            r_lap        <= w_lap_nxt;
            r_disp       <= (w_next == LAP) ? w_lap_nxt : w_count_nxt;
            r_running    <= (w_next == RUN) || (w_next == LAP);
            r_lap_active <= (w_next == LAP);
            if (clear)       r_overflow <= 1'b0;
            else if (w_wrap) r_overflow <= 1'b1;
        end
    end

    assign disp_bcd   = r_disp;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: default instance plus a MIN_MAX=0 instance for wrap.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        tk = 1'b0, ss = 1'b0, lp = 1'b0, cl = 1'b0;
    logic [27:0] disp;
    logic        run, lap_a, ovf;

    logic        o_tk = 1'b0, o_ss = 1'b0, o_lp = 1'b0, o_cl = 1'b0;
    logic [27:0] o_disp;
    logic        o_run, o_lap_a, o_ovf;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk_200(clk), .resetb(resetb), .ms_tick(tk), .start_stop(ss), .lap(lp), .clear(cl),
        .disp_bcd(disp), .running(run), .lap_active(lap_a), .overflow(ovf)
    );

    stopwatch_ctrl #(.MIN_MAX(0)) dut_ov (
        .clk_200(clk), .resetb(resetb), .ms_tick(o_tk), .start_stop(o_ss), .lap(o_lp), .clear(o_cl),
        .disp_bcd(o_disp), .running(o_run), .lap_active(o_lap_a), .overflow(o_ovf)
    );

    // One cycle of commands on the main instance; starts and ends at a falling edge.
    task automatic drive(input logic s, input logic l, input logic c, input logic t);
        ss = s; lp = l; cl = c; tk = t;
        @(negedge clk);
        ss = 0; lp = 0; cl = 0; tk = 0;
    endtask

    task automatic drive_ov(input logic s, input logic c, input logic t);
        o_ss = s; o_cl = c; o_tk = t;
        @(negedge clk);
        o_ss = 0; o_cl = 0; o_tk = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            drive(0, 0, 0, 1);
            @(negedge clk);
        end
    endtask

    task automatic burst(input int n);
        tk = 1;
        repeat (n) @(negedge clk);
        tk = 0;
    endtask

    task automatic test_reset;
        vec++; if (disp !== 28'h0)  begin err++; $display("FAIL reset_disp got %h want %h", disp, 28'h0); end
        vec++; if (run !== 1'b0)    begin err++; $display("FAIL reset_running got %b want 0", run); end
        vec++; if (lap_a !== 1'b0)  begin err++; $display("FAIL reset_lap_active got %b want 0", lap_a); end
        vec++; if (ovf !== 1'b0)    begin err++; $display("FAIL reset_overflow got %b want 0", ovf); end
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count;
        drive(1, 0, 0, 0);
        vec++; if (run !== 1'b1)   begin err++; $display("FAIL start_running got %b want 1", run); end
        vec++; if (disp !== 28'h0) begin err++; $display("FAIL start_disp got %h want %h", disp, 28'h0); end
        drive(0, 0, 0, 1);
        vec++; if (disp !== 28'h0000001) begin err++; $display("FAIL tick_latency got %h want %h", disp, 28'h0000001); end
        @(negedge clk);
        ticks(1233);
        vec++; if (disp !== 28'h0001234) begin err++; $display("FAIL count_1234 got %h want %h", disp, 28'h0001234); end
        vec++; if (run !== 1'b1)         begin err++; $display("FAIL count_running got %b want 1", run); end
        burst(3);
        vec++; if (disp !== 28'h0001237) begin err++; $display("FAIL burst_3 got %h want %h", disp, 28'h0001237); end
    endtask

    task automatic test_lap;
        drive(0, 0, 1, 0);
        vec++; if (disp !== 28'h0) begin err++; $display("FAIL lap_clear got %h want 0", disp); end
        drive(1, 0, 0, 0);
        burst(500);
        vec++; if (disp !== 28'h0000500) begin err++; $display("FAIL lap_pre got %h want %h", disp, 28'h0000500); end
        drive(0, 1, 0, 0);
        vec++; if (disp !== 28'h0000500) begin err++; $display("FAIL lap_freeze got %h want %h", disp, 28'h0000500); end
        vec++; if (lap_a !== 1'b1)       begin err++; $display("FAIL lap_active_on got %b want 1", lap_a); end
        burst(300);
        vec++; if (disp !== 28'h0000500) begin err++; $display("FAIL lap_held got %h want %h", disp, 28'h0000500); end
        vec++; if (run !== 1'b1)         begin err++; $display("FAIL lap_running got %b want 1", run); end
        drive(0, 1, 0, 0);
        vec++; if (disp !== 28'h0000800) begin err++; $display("FAIL lap_release got %h want %h", disp, 28'h0000800); end
        vec++; if (lap_a !== 1'b0)       begin err++; $display("FAIL lap_active_off got %b want 0", lap_a); end
        drive(0, 1, 0, 1);
        vec++; if (disp !== 28'h0000800) begin err++; $display("FAIL lap_pre_inc got %h want %h", disp, 28'h0000800); end
        drive(1, 0, 0, 0);
        vec++; if (disp !== 28'h0000801) begin err++; $display("FAIL lap_to_pause got %h want %h", disp, 28'h0000801); end
        vec++; if (run !== 1'b0 || lap_a !== 1'b0) begin err++; $display("FAIL lap_to_pause_flags got %b%b want 00", run, lap_a); end
    endtask

    task automatic test_pause_tick;
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        burst(2009);
        vec++; if (disp !== 28'h0002009) begin err++; $display("FAIL pause_pre got %h want %h", disp, 28'h0002009); end
        drive(1, 0, 0, 1);
        vec++; if (disp !== 28'h0002010) begin err++; $display("FAIL pause_tick got %h want %h", disp, 28'h0002010); end
        vec++; if (run !== 1'b0)         begin err++; $display("FAIL pause_running got %b want 0", run); end
        burst(5);
        vec++; if (disp !== 28'h0002010) begin err++; $display("FAIL pause_hold got %h want %h", disp, 28'h0002010); end
        drive(0, 1, 0, 0);
        vec++; if (lap_a !== 1'b0 || run !== 1'b0) begin err++; $display("FAIL pause_lap_ignored got %b%b want 00", run, lap_a); end
        drive(1, 0, 0, 1);
        vec++; if (disp !== 28'h0002010) begin err++; $display("FAIL resume_tick_dropped got %h want %h", disp, 28'h0002010); end
        vec++; if (run !== 1'b1)         begin err++; $display("FAIL resume_running got %b want 1", run); end
        drive(0, 0, 0, 1);
        vec++; if (disp !== 28'h0002011) begin err++; $display("FAIL resume_count got %h want %h", disp, 28'h0002011); end
    endtask

    task automatic test_back_to_back;
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        vec++; if (run !== 1'b1)   begin err++; $display("FAIL b2b_start got %b want 1", run); end
        drive(0, 1, 0, 0);
        vec++; if (lap_a !== 1'b1) begin err++; $display("FAIL b2b_lap got %b want 1", lap_a); end
        drive(0, 1, 0, 0);
        vec++; if (lap_a !== 1'b0 || run !== 1'b1) begin err++; $display("FAIL b2b_unlap got %b%b want 10", run, lap_a); end
        drive(1, 0, 0, 0);
        vec++; if (run !== 1'b0)   begin err++; $display("FAIL b2b_pause got %b want 0", run); end
        drive(1, 0, 0, 0);
        vec++; if (run !== 1'b1)   begin err++; $display("FAIL b2b_resume got %b want 1", run); end
    endtask

    task automatic test_clear_all;
        burst(7);
        drive(0, 1, 0, 0);
        vec++; if (lap_a !== 1'b1) begin err++; $display("FAIL clr_setup_lap got %b want 1", lap_a); end
        drive(1, 1, 1, 1);
        vec++; if (disp !== 28'h0) begin err++; $display("FAIL clr_all_disp got %h want 0", disp); end
        vec++; if (run !== 1'b0 || lap_a !== 1'b0) begin err++; $display("FAIL clr_all_flags got %b%b want 00", run, lap_a); end
        drive(0, 1, 0, 1);
        vec++; if (run !== 1'b0 || lap_a !== 1'b0 || disp !== 28'h0) begin err++; $display("FAIL idle_ignore got %b%b %h want 00 0", run, lap_a, disp); end
        drive(1, 0, 0, 0);
        vec++; if (run !== 1'b1)   begin err++; $display("FAIL clr_restart got %b want 1", run); end
    endtask

    task automatic test_reset_mid;
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        burst(10000);
        vec++; if (disp !== 28'h0010000) begin err++; $display("FAIL mid_pre got %h want %h", disp, 28'h0010000); end
        tk = 1;
        @(posedge clk);
        #2 resetb = 1'b0;
        #1;
        vec++; if (disp !== 28'h0 || run !== 1'b0 || lap_a !== 1'b0 || ovf !== 1'b0)
            begin err++; $display("FAIL mid_async got %h %b%b%b want 0 000", disp, run, lap_a, ovf); end
        @(negedge clk);
        tk = 0;
        resetb = 1'b1;
        drive(1, 0, 0, 0);
        vec++; if (disp !== 28'h0 || run !== 1'b1) begin err++; $display("FAIL mid_restart got %h %b want 0 1", disp, run); end
        drive(0, 0, 0, 1);
        vec++; if (disp !== 28'h0000001) begin err++; $display("FAIL mid_first_tick got %h want %h", disp, 28'h0000001); end
    endtask

    task automatic test_overflow;
        drive_ov(1, 0, 0);
        o_tk = 1;
        repeat (59998) @(negedge clk);
        o_tk = 0;
        vec++; if (o_disp !== 28'h0059998) begin err++; $display("FAIL ov_pre got %h want %h", o_disp, 28'h0059998); end
        drive_ov(0, 0, 1);
        vec++; if (o_disp !== 28'h0059999 || o_ovf !== 1'b0) begin err++; $display("FAIL ov_top got %h %b want %h 0", o_disp, o_ovf, 28'h0059999); end
        drive_ov(0, 0, 1);
        vec++; if (o_disp !== 28'h0 || o_ovf !== 1'b1) begin err++; $display("FAIL ov_wrap got %h %b want 0 1", o_disp, o_ovf); end
        drive_ov(0, 0, 1);
        vec++; if (o_disp !== 28'h0000001 || o_ovf !== 1'b1) begin err++; $display("FAIL ov_sticky got %h %b want 1 1", o_disp, o_ovf); end
        drive_ov(0, 1, 0);
        vec++; if (o_ovf !== 1'b0 || o_run !== 1'b0 || o_disp !== 28'h0) begin err++; $display("FAIL ov_clear got %b %b %h want 0 0 0", o_ovf, o_run, o_disp); end
    endtask

    initial begin
        #12;
        test_reset;
        test_count;
        test_lap;
        test_pause_tick;
        test_back_to_back;
        test_clear_all;
        test_overflow;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
